ex_mem: RTL and testbench
=========================

// Module: ex_mem
// PURPOSE
//   EX->MEM pipeline stage. Registers the EX result payload and hands it to
//   the MEM stage over a valid/ready handshake. A 2-entry skid (main + skid)
//   keeps ex_ready dependent only on local state, so there is no combinational
//   ready path from MEM back to EX. Supports a synchronous flush and nop-bubble
//   insertion.
// PARAMETERS
//   DATA_W  64  width of alu result / store data
//   PC_W    64  width of pc
//   INST_W  32  width of instruction
//   REG_W   5   width of rd address
// PORTS
//   clock          in   1       rising-edge clock
//   reset          in   1       asynchronous, active-low reset
//   flush          in   1       sync kill of all held entries
//   nop            in   1       accepted beat is replaced by a bubble
//   ex_valid       in   1       EX offers a beat
//   ex_ready       out  1       stage can accept a beat
//   mem_valid      out  1       MEM_* outputs hold a valid beat
//   mem_ready      in   1       MEM consumes the beat this cycle
//   EX_w_ena       in   1       regfile write enable
//   EX_w_addr      in   REG_W   rd
//   EX_result      in   DATA_W  alu result / memory address
//   EX_sdata       in   DATA_W  store data
//   EX_memwop      in   3       store width op
//   EX_memrop      in   3       load width/sign op
//   EX_mem_ena     in   1       memory access enable
//   EX_mem_wr      in   1       1 = write, 0 = read
//   EX_pc          in   PC_W    pc
//   EX_instr       in   INST_W  instruction
//   MEM_*          out  same    registered copies of the EX_* fields above
// BEHAVIOUR
//   - Reset (reset==0, async): state=EMPTY; every MEM_* = 0
//     (w_ena/mem_ena = N_ENA, memwop/memrop = MNO, mem_wr = READ,
//     instr = NONE_INST); mem_valid=0; ex_ready=1.
//   - in_fire = ex_valid & ex_ready; out_fire = mem_valid & mem_ready.
//   - ex_ready = (state != SKID). mem_valid = (state != EMPTY).
//     Both are functions of state only.
//   - MEM_* always show the main entry. Latency is 1 cycle when empty.
//   - State machine:
//     EMPTY: in_fire -> FULL, main<=beat.
//     FULL:  in_fire &  out_fire -> FULL, main<=beat.
//            in_fire & ~out_fire -> SKID, skid<=beat.
//           ~in_fire &  out_fire -> EMPTY.
//           ~in_fire & ~out_fire -> FULL, hold.
//     SKID:  out_fire -> FULL, main<=skid. No accept (ex_ready=0).
//   - beat = nop ? bubble : EX_*. A bubble is the reset payload with pc/instr
//     zero. A bubble still occupies a slot and asserts mem_valid.
//   - flush=1 (priority over all): next state=EMPTY; main and skid
//     w_ena/mem_ena cleared. A beat offered in the flush cycle is dropped even
//     if ex_ready=1. MEM sees mem_valid=0 on the next cycle.
//   - MEM_* hold stable while mem_valid & ~mem_ready.
//   - No beat is ever lost or duplicated. Order is strictly FIFO.
//   - Async reset mid-transfer discards both entries immediately.
// TESTING
//   1 reset low, then high with ex_valid=1, w_addr=5, result=64'h10, ready=1
//     -> next cycle mem_valid=1, MEM_w_addr=5, MEM_result=64'h10.
//   2 stream A,B,C back-to-back, mem_ready=1 -> A,B,C on MEM one per cycle;
//     ex_ready stays 1.
//   3 hold A with mem_ready=0, offer B -> SKID, ex_ready=0, MEM shows A;
//     raise ready -> A then B, ex_ready returns to 1.
//   4 SKID state + flush=1 -> next cycle mem_valid=0, ex_ready=1;
//     neither A nor B is ever presented.
//   5 ex_valid=1, nop=1, EX_w_ena=1, EX_mem_ena=1 -> mem_valid=1,
//     MEM_w_ena=0, MEM_mem_ena=0, MEM_instr=NONE_INST.
//   6 assert reset mid-SKID between clock edges -> all outputs reset at once,
//     without waiting for an edge.

Source files
------------

// File: rtl/ex_mem.sv
`default_nettype none
// ============================================================================
// ex_mem : EX->MEM pipeline register with 2-entry skid, flush and nop bubble
// Rev 1.0
// ============================================================================
module ex_mem #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              nop,
  input  logic              ex_valid,
  output logic              ex_ready,
  output logic              mem_valid,
  input  logic              mem_ready,
  input  logic              EX_w_ena,
  input  logic [REG_W-1:0]  EX_w_addr,
  input  logic [DATA_W-1:0] EX_result,
  input  logic [DATA_W-1:0] EX_sdata,
  input  logic [2:0]        EX_memwop,
  input  logic [2:0]        EX_memrop,
  input  logic              EX_mem_ena,
  input  logic              EX_mem_wr,
  input  logic [PC_W-1:0]   EX_pc,
  input  logic [INST_W-1:0] EX_instr,
  output logic              MEM_w_ena,
  output logic [REG_W-1:0]  MEM_w_addr,
  output logic [DATA_W-1:0] MEM_result,
  output logic [DATA_W-1:0] MEM_sdata,
  output logic [2:0]        MEM_memwop,
  output logic [2:0]        MEM_memrop,
  output logic              MEM_mem_ena,
  output logic              MEM_mem_wr,
  output logic [PC_W-1:0]   MEM_pc,
  output logic [INST_W-1:0] MEM_instr
);

  localparam logic              c_N_ENA     = 1'b0;
  localparam logic [2:0]        c_MNO       = 3'b000;
  localparam logic              c_READ      = 1'b0;
  localparam logic [INST_W-1:0] c_NONE_INST = '0;

  typedef struct packed {
    logic              w_ena;
    logic [REG_W-1:0]  w_addr;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] sdata;
    logic [2:0]        memwop;
    logic [2:0]        memrop;
    logic              mem_ena;
    logic              mem_wr;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] instr;
  } payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t   r_state;
  payload_t r_main;
  payload_t r_skid;
  payload_t w_beat;
  payload_t w_bubble;
  logic     w_in_fire;
  logic     w_out_fire;

  // Handshake flags decode state only, so MEM never reaches back to EX combinationally.
  assign ex_ready   = (r_state != S_SKID);
  assign mem_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = ex_valid & ex_ready;
  assign w_out_fire = mem_valid & mem_ready;

  always_comb begin
    w_bubble         = '0;
    w_bubble.w_ena   = c_N_ENA;
    w_bubble.memwop  = c_MNO;
    w_bubble.memrop  = c_MNO;
    w_bubble.mem_ena = c_N_ENA;
    w_bubble.mem_wr  = c_READ;
    w_bubble.instr   = c_NONE_INST;
    if (nop) begin
      w_beat = w_bubble;
    end else begin
      w_beat = '{w_ena: EX_w_ena, w_addr: EX_w_addr, result: EX_result,
                 sdata: EX_sdata, memwop: EX_memwop, memrop: EX_memrop,
                 mem_ena: EX_mem_ena, mem_wr: EX_mem_wr, pc: EX_pc,
                 instr: EX_instr};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      // Killing the enables is enough: stale fields never matter once EMPTY.
      r_state        <= S_EMPTY;
      r_main.w_ena   <= c_N_ENA;
      r_main.mem_ena <= c_N_ENA;
      r_skid.w_ena   <= c_N_ENA;
      r_skid.mem_ena <= c_N_ENA;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_main  <= w_beat;
            r_state <= S_FULL;
          end
        end
        S_FULL: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= w_beat;
          end else if (w_in_fire) begin
            r_skid  <= w_beat;
            r_state <= S_SKID;
          end else if (w_out_fire) begin
            r_state <= S_EMPTY;
          end
        end
        S_SKID: begin
          if (w_out_fire) begin
            r_main  <= r_skid;
            r_state <= S_FULL;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign MEM_w_ena   = r_main.w_ena;
  assign MEM_w_addr  = r_main.w_addr;
  assign MEM_result  = r_main.result;
  assign MEM_sdata   = r_main.sdata;
  assign MEM_memwop  = r_main.memwop;
  assign MEM_memrop  = r_main.memrop;
  assign MEM_mem_ena = r_main.mem_ena;
  assign MEM_mem_wr  = r_main.mem_wr;
  assign MEM_pc      = r_main.pc;
  assign MEM_instr   = r_main.instr;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem.sv
`default_nettype none
// tb_ex_mem : scoreboard bench for the EX->MEM skid stage.
module tb_ex_mem;

  typedef struct packed {
    logic        w_ena;
    logic [4:0]  w_addr;
    logic [63:0] result;
    logic [63:0] sdata;
    logic [2:0]  memwop;
    logic [2:0]  memrop;
    logic        mem_ena;
    logic        mem_wr;
    logic [63:0] pc;
    logic [31:0] instr;
  } beat_t;

  logic        clock, reset, flush, nop, ex_valid, ex_ready, mem_valid, mem_ready;
  logic        EX_w_ena, EX_mem_ena, EX_mem_wr;
  logic [4:0]  EX_w_addr;
  logic [63:0] EX_result, EX_sdata, EX_pc;
  logic [2:0]  EX_memwop, EX_memrop;
  logic [31:0] EX_instr;
  logic        MEM_w_ena, MEM_mem_ena, MEM_mem_wr;
  logic [4:0]  MEM_w_addr;
  logic [63:0] MEM_result, MEM_sdata, MEM_pc;
  logic [2:0]  MEM_memwop, MEM_memrop;
  logic [31:0] MEM_instr;

  int    n_pass  = 0;
  int    n_total = 0;
  beat_t q[$];

  ex_mem dut (
    .clock(clock), .reset(reset), .flush(flush), .nop(nop),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .EX_w_ena(EX_w_ena), .EX_w_addr(EX_w_addr), .EX_result(EX_result),
    .EX_sdata(EX_sdata), .EX_memwop(EX_memwop), .EX_memrop(EX_memrop),
    .EX_mem_ena(EX_mem_ena), .EX_mem_wr(EX_mem_wr), .EX_pc(EX_pc),
    .EX_instr(EX_instr),
    .MEM_w_ena(MEM_w_ena), .MEM_w_addr(MEM_w_addr), .MEM_result(MEM_result),
    .MEM_sdata(MEM_sdata), .MEM_memwop(MEM_memwop), .MEM_memrop(MEM_memrop),
    .MEM_mem_ena(MEM_mem_ena), .MEM_mem_wr(MEM_mem_wr), .MEM_pc(MEM_pc),
    .MEM_instr(MEM_instr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic beat_t mem_out();
    return '{MEM_w_ena, MEM_w_addr, MEM_result, MEM_sdata, MEM_memwop,
             MEM_memrop, MEM_mem_ena, MEM_mem_wr, MEM_pc, MEM_instr};
  endfunction

  function automatic beat_t mk(input int id);
    beat_t b;
    b.w_ena   = 1'b1;
    b.w_addr  = 5'(id * 3 + 1);
    b.result  = 64'h1000_0000_0000_0000 + 64'(id);
    b.sdata   = 64'hA5A5_0000_0000_0000 | 64'(id * 17);
    b.memwop  = 3'(id);
    b.memrop  = 3'(id + 1);
    b.mem_ena = 1'b1;
    b.mem_wr  = id[0];
    b.pc      = 64'h8000_0000 + 64'(id * 4);
    b.instr   = 32'h0000_0013 | 32'(id << 7);
    return b;
  endfunction

  // Monitor: every presented and consumed beat must match the queue head.
  always @(negedge clock) begin
    if (mem_valid === 1'b1 && mem_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got %0h expected none", mem_out());
      end else begin
        chk("mem_beat", 256'(mem_out()), 256'(q.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1 with ex_valid dropped.
  task automatic drive(input beat_t b, input logic nopv);
    {EX_w_ena, EX_w_addr, EX_result, EX_sdata, EX_memwop, EX_memrop,
     EX_mem_ena, EX_mem_wr, EX_pc, EX_instr} = b;
    nop      = nopv;
    ex_valid = 1'b1;
    @(negedge clock);
    if (ex_ready === 1'b1 && !flush) q.push_back(nopv ? beat_t'('0) : b);
    @(posedge clock);
    #1;
    ex_valid = 1'b0;
    nop      = 1'b0;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    beat_t b;
    reset = 1'b1; flush = 1'b0; nop = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
    {EX_w_ena, EX_w_addr, EX_result, EX_sdata, EX_memwop, EX_memrop,
     EX_mem_ena, EX_mem_wr, EX_pc, EX_instr} = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset_mem_valid", 256'(mem_valid), 256'(1'b0));
    chk("reset_ex_ready", 256'(ex_ready), 256'(1'b1));
    chk("reset_payload", 256'(mem_out()), 256'(0));
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    mem_ready = 1'b1;

    // 1: first beat after reset, one-cycle latency
    b = '0; b.w_addr = 5'd5; b.result = 64'h10;
    drive(b, 1'b0);
    chk("t1_mem_valid", 256'(mem_valid), 256'(1'b1));
    chk("t1_w_addr", 256'(MEM_w_addr), 256'(5'd5));
    chk("t1_result", 256'(MEM_result), 256'(64'h10));
    idle();

    // 2: back-to-back stream, ex_ready never drops
    for (int i = 0; i < 3; i++) begin
      drive(mk(i), 1'b0);
      chk("t2_ex_ready", 256'(ex_ready), 256'(1'b1));
    end
    idle();
    idle();

    // 3: backpressure fills skid, then drains in order
    mem_ready = 1'b0;
    drive(mk(10), 1'b0);
    drive(mk(11), 1'b0);
    chk("t3_skid_ex_ready", 256'(ex_ready), 256'(1'b0));
    chk("t3_skid_mem_valid", 256'(mem_valid), 256'(1'b1));
    chk("t3_hold_result", 256'(MEM_result), 256'(64'h1000_0000_0000_000A));
    idle();
    chk("t3_hold_stable", 256'(MEM_result), 256'(64'h1000_0000_0000_000A));
    mem_ready = 1'b1;
    idle();
    chk("t3_after_a_ex_ready", 256'(ex_ready), 256'(1'b1));
    chk("t3_after_a_result", 256'(MEM_result), 256'(64'h1000_0000_0000_000B));
    idle();
    chk("t3_drained_valid", 256'(mem_valid), 256'(1'b0));

    // 4: flush in SKID, then flush drops an acceptable beat
    mem_ready = 1'b0;
    drive(mk(20), 1'b0);
    drive(mk(21), 1'b0);
    flush = 1'b1;
    ex_valid = 1'b1;
    q.delete();
    @(posedge clock);
    #1;
    ex_valid = 1'b0;
    chk("t4_flush_mem_valid", 256'(mem_valid), 256'(1'b0));
    chk("t4_flush_ex_ready", 256'(ex_ready), 256'(1'b1));
    drive(mk(22), 1'b0);
    flush = 1'b0;
    chk("t4_flush_drop", 256'(mem_valid), 256'(1'b0));
    mem_ready = 1'b1;
    idle();
    idle();

    // 5: nop bubble
    b = mk(7); b.w_ena = 1'b1; b.mem_ena = 1'b1;
    drive(b, 1'b1);
    chk("t5_mem_valid", 256'(mem_valid), 256'(1'b1));
    chk("t5_w_ena", 256'(MEM_w_ena), 256'(1'b0));
    chk("t5_mem_ena", 256'(MEM_mem_ena), 256'(1'b0));
    chk("t5_instr", 256'(MEM_instr), 256'(32'h0));
    idle();
    idle();

    // 6: async reset mid-SKID, between edges
    mem_ready = 1'b0;
    drive(mk(30), 1'b0);
    drive(mk(31), 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t6_mem_valid", 256'(mem_valid), 256'(1'b0));
    chk("t6_ex_ready", 256'(ex_ready), 256'(1'b1));
    chk("t6_payload", 256'(mem_out()), 256'(0));
    q.delete();
    #1 reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock);
    #1;
    idle();
    idle();

    chk("final_queue_empty", 256'(q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
